// File: rtl/tri_sched_pkg.sv
// Shared types and constants for the triangle scheduler: FSM encoding,
// colour-index width and the "farthest depth" helper.
package tri_sched_pkg;

  localparam int TRI_IDX_W = 3;
  localparam logic [TRI_IDX_W-1:0] COLOR_BG = 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

  // All-ones value of the given width; callers truncate to their depth width
  function automatic logic [31:0] depth_far(input int width);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/tri_next_enabled.sv
// Priority search: lowest set bit of the mask whose index is >= start,
// plus a flag when no such bit exists.
module tri_next_enabled
  import tri_sched_pkg::*;
#(
  parameter int NUM_TRIS = 4
) (
  input  logic [NUM_TRIS-1:0]  mask,
  input  logic [TRI_IDX_W-1:0] start,
  output logic [TRI_IDX_W-1:0] idx,
  output logic                 none_left
);

  // Scan downward so the lowest qualifying slot is the last one written
  always_comb begin
    idx       = TRI_IDX_W'(0);
    none_left = 1'b1;
    for (int i = NUM_TRIS - 1; i >= 0; i--) begin
      if (mask[i] && (TRI_IDX_W'(i) >= start)) begin
        idx       = TRI_IDX_W'(i);
        none_left = 1'b0;
      end else begin
        none_left = none_left;
      end
    end
  end

endmodule

// File: rtl/tri_scheduler.sv
// Shares one barycentric/depth evaluator across the enabled triangles of a
// pixel and returns the colour index of the nearest hit.
module tri_scheduler
  import tri_sched_pkg::*;
#(
  parameter int NUM_TRIS  = 4,
  parameter int EVAL_BITS = 7,
  parameter int DEPTH_W   = 8,
  parameter int TIMEOUT   = 15
) (
  input  logic                  mclk,
  input  logic                  reset,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [EVAL_BITS-1:0]  pix_x,
  input  logic [EVAL_BITS-1:0]  pix_y,
  input  logic [NUM_TRIS-1:0]   tri_enable,
  output logic                  eval_strobe,
  output logic [TRI_IDX_W-1:0]  tri_sel,
  output logic [EVAL_BITS-1:0]  eval_x,
  output logic [EVAL_BITS-1:0]  eval_y,
  input  logic                  eval_valid,
  input  logic                  eval_in_tris,
  input  logic [DEPTH_W-1:0]    eval_depth,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TRI_IDX_W-1:0]  out_color,
  output logic                  out_hit,
  output logic                  err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [DEPTH_W-1:0] DEPTH_FAR = DEPTH_W'(depth_far(DEPTH_W));
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  sched_state_t          state_r;
  logic [NUM_TRIS-1:0]   mask_r;
  logic [DEPTH_W-1:0]    best_depth_r;
  logic [CNT_W-1:0]      wait_cnt_r;
  logic [NUM_TRIS-1:0]   search_mask_s;
  logic [TRI_IDX_W-1:0]  search_start_s;
  logic [TRI_IDX_W-1:0]  next_idx_s;
  logic                  none_left_s;
  logic                  better_s;
  logic                  slot_done_s;

  tri_next_enabled #(
    .NUM_TRIS(NUM_TRIS)
  ) u_next (
    .mask      (search_mask_s),
    .start     (search_start_s),
    .idx       (next_idx_s),
    .none_left (none_left_s)
  );

  // On accept search the live mask from slot 0; afterwards search the snapshot past tri_sel
  always_comb begin
    search_mask_s  = mask_r;
    search_start_s = tri_sel + TRI_IDX_W'(1);
    if (state_r == ST_IDLE) begin
      search_mask_s  = tri_enable;
      search_start_s = TRI_IDX_W'(0);
    end else begin
      search_mask_s  = mask_r;
      search_start_s = tri_sel + TRI_IDX_W'(1);
    end
  end

  // A slot finishes on an answer or when the wait budget runs out
  always_comb begin
    better_s    = eval_valid && eval_in_tris && (eval_depth < best_depth_r);
    slot_done_s = eval_valid || (wait_cnt_r == CNT_LAST);
  end

  // Scheduler FSM; out_color/out_hit double as the running best index and hit
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      pix_ready    <= 1'b1;
      eval_strobe  <= 1'b0;
      tri_sel      <= TRI_IDX_W'(0);
      eval_x       <= '0;
      eval_y       <= '0;
      mask_r       <= '0;
      out_valid    <= 1'b0;
      out_color    <= COLOR_BG;
      out_hit      <= 1'b0;
      err_timeout  <= 1'b0;
      best_depth_r <= DEPTH_FAR;
      wait_cnt_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pix_valid) begin
            eval_x       <= pix_x;
            eval_y       <= pix_y;
            mask_r       <= tri_enable;
            out_color    <= COLOR_BG;
            out_hit      <= 1'b0;
            best_depth_r <= DEPTH_FAR;
            pix_ready    <= 1'b0;
            if (!none_left_s) begin
              state_r     <= ST_ISSUE;
              eval_strobe <= 1'b1;
              tri_sel     <= next_idx_s;
            end else begin
              state_r   <= ST_DONE;
              out_valid <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          eval_strobe <= 1'b0;
          wait_cnt_r  <= '0;
          state_r     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (slot_done_s) begin
            if (!eval_valid) begin
              err_timeout <= 1'b1;
            end
            if (better_s) begin
              out_hit      <= 1'b1;
              out_color    <= tri_sel + TRI_IDX_W'(1);
              best_depth_r <= eval_depth;
            end
            if (!none_left_s) begin
              state_r     <= ST_ISSUE;
              eval_strobe <= 1'b1;
              tri_sel     <= next_idx_s;
            end else begin
              state_r   <= ST_DONE;
              out_valid <= 1'b1;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            pix_ready <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          pix_ready   <= 1'b1;
          eval_strobe <= 1'b0;
          out_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tri_scheduler.sv
// Randomised bench for tri_scheduler: an evaluator stub answers from per-slot
// tables and a reference model predicts colour, hit, strobe order and latency.
module tb_tri_scheduler;

  localparam int NT = 4;
  localparam int EB = 7;
  localparam int DW = 8;
  localparam int TO = 15;

  logic          mclk;
  logic          reset;
  logic          pix_valid;
  logic          pix_ready;
  logic [EB-1:0] pix_x;
  logic [EB-1:0] pix_y;
  logic [NT-1:0] tri_enable;
  logic          eval_strobe;
  logic [2:0]    tri_sel;
  logic [EB-1:0] eval_x;
  logic [EB-1:0] eval_y;
  logic          eval_valid;
  logic          eval_in_tris;
  logic [DW-1:0] eval_depth;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    out_color;
  logic          out_hit;
  logic          err_timeout;

  tri_scheduler #(
    .NUM_TRIS(NT), .EVAL_BITS(EB), .DEPTH_W(DW), .TIMEOUT(TO)
  ) dut (
    .mclk(mclk), .reset(reset),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .tri_enable(tri_enable),
    .eval_strobe(eval_strobe), .tri_sel(tri_sel),
    .eval_x(eval_x), .eval_y(eval_y),
    .eval_valid(eval_valid), .eval_in_tris(eval_in_tris), .eval_depth(eval_depth),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_color(out_color), .out_hit(out_hit), .err_timeout(err_timeout)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Evaluator stub tables: latency 0 means the evaluator never answers
  bit t_in    [NT];
  int t_depth [NT];
  int t_lat   [NT];

  bit resp_pending = 1'b0;
  int resp_cnt     = 0;
  int resp_sel     = 0;
  int seen_sel[$];
  bit err_exp      = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then play the evaluator for the new cycle
  task automatic step();
    @(posedge mclk);
    #1;
    eval_valid   = 1'b0;
    eval_in_tris = 1'($urandom);
    eval_depth   = DW'($urandom);
    if (resp_pending) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        eval_valid   = 1'b1;
        eval_in_tris = t_in[resp_sel];
        eval_depth   = DW'(t_depth[resp_sel]);
        resp_pending = 1'b0;
      end
    end
    if (eval_strobe) begin
      seen_sel.push_back(int'(tri_sel));
      if (t_lat[tri_sel] != 0) begin
        resp_pending = 1'b1;
        resp_cnt     = t_lat[tri_sel];
        resp_sel     = int'(tri_sel);
      end
    end
  endtask

  task automatic run_pixel(input logic [NT-1:0] mask, input logic [EB-1:0] x,
                           input logic [EB-1:0] y, input int hold, input bit toggle);
    int exp_sel[$];
    int exp_lat;
    int best_d;
    int exp_col;
    bit exp_hit;
    int k;

    // Reference: ascending enabled slots, strictly nearer hit wins, silent slot costs TO cycles
    exp_lat = 1;
    best_d  = (1 << DW) - 1;
    exp_col = 0;
    exp_hit = 1'b0;
    for (int t = 0; t < NT; t++) begin
      if (mask[t]) begin
        exp_sel.push_back(t);
        if (t_lat[t] == 0) begin
          exp_lat += 1 + TO;
          err_exp = 1'b1;
        end else begin
          exp_lat += 1 + t_lat[t];
          if (t_in[t] && t_depth[t] < best_d) begin
            best_d  = t_depth[t];
            exp_col = t + 1;
            exp_hit = 1'b1;
          end
        end
      end
    end

    k = 0;
    while (!pix_ready && k < 50) begin
      step();
      k++;
    end
    check_eq("pix_ready_before_accept", 32'(pix_ready), 32'd1);

    seen_sel.delete();
    pix_valid  = 1'b1;
    pix_x      = x;
    pix_y      = y;
    tri_enable = mask;
    step();
    pix_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 400) begin
      tri_enable = NT'($urandom);
      step();
      k++;
    end
    check_eq("out_valid_seen", 32'(out_valid), 32'd1);
    check_eq("latency", 32'(k), 32'(exp_lat));
    check_eq("out_color", 32'(out_color), 32'(exp_col));
    check_eq("out_hit", 32'(out_hit), 32'(exp_hit));
    check_eq("err_timeout", 32'(err_timeout), 32'(err_exp));
    check_eq("eval_x", 32'(eval_x), 32'(x));
    check_eq("eval_y", 32'(eval_y), 32'(y));
    check_eq("strobe_count", 32'(seen_sel.size()), 32'(exp_sel.size()));
    for (int i = 0; i < exp_sel.size(); i++) begin
      if (i < seen_sel.size()) begin
        check_eq("strobe_tri_sel", 32'(seen_sel[i]), 32'(exp_sel[i]));
      end
    end

    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      if (toggle) begin
        pix_valid  = 1'($urandom);
        tri_enable = NT'($urandom);
      end
      step();
      check_eq("hold_out_valid", 32'(out_valid), 32'd1);
      check_eq("hold_out_color", 32'(out_color), 32'(exp_col));
      check_eq("hold_out_hit", 32'(out_hit), 32'(exp_hit));
      check_eq("hold_pix_ready", 32'(pix_ready), 32'd0);
    end

    pix_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("post_hs_out_valid", 32'(out_valid), 32'd0);
    check_eq("post_hs_pix_ready", 32'(pix_ready), 32'd1);
  endtask

  initial begin
    reset        = 1'b1;
    pix_valid    = 1'b0;
    pix_x        = '0;
    pix_y        = '0;
    tri_enable   = '0;
    eval_valid   = 1'b0;
    eval_in_tris = 1'b0;
    eval_depth   = '0;
    out_ready    = 1'b0;
    for (int t = 0; t < NT; t++) begin
      t_in[t] = 1'b0; t_depth[t] = 0; t_lat[t] = 2;
    end
    repeat (3) @(posedge mclk);
    #1;
    check_eq("rst_pix_ready", 32'(pix_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_eval_strobe", 32'(eval_strobe), 32'd0);
    check_eq("rst_err_timeout", 32'(err_timeout), 32'd0);
    check_eq("rst_out_color", 32'(out_color), 32'd0);
    check_eq("rst_tri_sel", 32'(tri_sel), 32'd0);
    reset = 1'b0;
    step();

    // Empty mask: immediate background result
    run_pixel(4'b0000, 7'd10, 7'd20, 0, 1'b0);

    // All four slots, L=2: tri1 depth 3, tri2 depth 1
    t_in[1] = 1'b1; t_depth[1] = 3;
    t_in[2] = 1'b1; t_depth[2] = 1;
    run_pixel(4'b1111, 7'd33, 7'd44, 0, 1'b0);

    // Depth tie between tri1 and tri3 keeps the lower index
    for (int t = 0; t < NT; t++) begin
      t_in[t] = 1'b1; t_depth[t] = 5; t_lat[t] = 1;
    end
    run_pixel(4'b1010, 7'd1, 7'd127, 0, 1'b0);

    // Silent evaluator on tri0, tri1 hits
    t_lat[0] = 0; t_lat[1] = 3; t_in[1] = 1'b1; t_depth[1] = 9;
    run_pixel(4'b0011, 7'd5, 7'd6, 0, 1'b0);

    // Stalled consumer with noisy inputs; err_timeout must stay sticky
    t_lat[0] = 2;
    run_pixel(4'b0111, 7'd70, 7'd80, 10, 1'b1);

    // Reset while waiting on the evaluator
    for (int t = 0; t < NT; t++) t_lat[t] = 5;
    while (!pix_ready) step();
    pix_valid = 1'b1; tri_enable = 4'b1111;
    step();
    pix_valid = 1'b0;
    step();
    step();
    #2;
    reset = 1'b1;
    resp_pending = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_eval_strobe", 32'(eval_strobe), 32'd0);
    check_eq("midrst_tri_sel", 32'(tri_sel), 32'd0);
    check_eq("midrst_err_timeout", 32'(err_timeout), 32'd0);
    check_eq("midrst_eval_x", 32'(eval_x), 32'd0);
    step();
    reset = 1'b0;
    resp_pending = 1'b0;
    err_exp = 1'b0;
    eval_valid = 1'b1; eval_in_tris = 1'b1; eval_depth = '0;
    step();
    check_eq("late_eval_out_valid", 32'(out_valid), 32'd0);
    check_eq("late_eval_strobe", 32'(eval_strobe), 32'd0);
    check_eq("late_eval_pix_ready", 32'(pix_ready), 32'd1);
    for (int t = 0; t < NT; t++) begin
      t_in[t] = 1'b1; t_depth[t] = 20 - t; t_lat[t] = 1;
    end
    run_pixel(4'b0110, 7'd9, 7'd9, 0, 1'b0);

    // Random traffic
    for (int p = 0; p < 40; p++) begin
      for (int t = 0; t < NT; t++) begin
        t_in[t]    = ($urandom_range(0, 3) != 0);
        t_depth[t] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 255));
        t_lat[t]   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 5));
      end
      run_pixel(NT'($urandom), EB'($urandom), EB'($urandom), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tri_scheduler.md
Name: tri_scheduler

Overview:
- Time-multiplexes one barycentric/depth evaluator across up to NUM_TRIS triangles for each pixel request from the VGA front end.
- Per pixel: issues one evaluation per enabled triangle, keeps the nearest hit, and returns a 3-bit colour index for the palette stage. Index 0 is background; index t+1 means triangle t.
- Sits between the pixel/Sync counters and the per-pixel colour register; runs on mclk.

Parameters:
- NUM_TRIS, 4, number of triangle slots; legal range 1..7 (colour index is 3 bits).
- EVAL_BITS, 7, width of pixel evaluation coordinates.
- DEPTH_W, 8, width of the unsigned evaluator depth; smaller value is nearer.
- TIMEOUT, 15, maximum cycles spent in WAIT for one evaluation before forcing a miss.

Ports:
- mclk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pix_valid  in  1  pixel request valid.
- pix_ready  out  1  scheduler can accept a request; high only in IDLE.
- pix_x  in  EVAL_BITS  pixel x, captured on accept.
- pix_y  in  EVAL_BITS  pixel y, captured on accept.
- tri_enable  in  NUM_TRIS  per-triangle enable mask, snapshotted on accept.
- eval_strobe  out  1  one-cycle start pulse to the evaluator.
- tri_sel  out  3  triangle index for the evaluator's vertex mux; valid with eval_strobe and held through WAIT.
- eval_x  out  EVAL_BITS  registered copy of pix_x.
- eval_y  out  EVAL_BITS  registered copy of pix_y.
- eval_valid  in  1  evaluator result valid.
- eval_in_tris  in  1  pixel lies inside the selected triangle.
- eval_depth  in  DEPTH_W  depth of the selected triangle at this pixel.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- out_color  out  3  winning colour index (0 = background).
- out_hit  out  1  at least one triangle hit.
- err_timeout  out  1  sticky flag; set on any evaluator timeout.

Behaviour:
- Reset (asynchronous):
  - state = IDLE, so pix_ready = 1.
  - eval_strobe, out_valid, out_color, out_hit, err_timeout, tri_sel, eval_x, eval_y = 0.
  - best depth and timeout counter cleared.
- A reset asserted mid-pixel abandons the pixel with no output.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Accept when pix_valid & pix_ready. Capture x, y and the tri_enable mask.
  - Clear best: hit = 0, index = 0, depth = all-ones.
  - Next state is ISSUE if the mask is nonzero, otherwise DONE.
- ISSUE (exactly 1 cycle):
  - eval_strobe = 1; tri_sel = lowest enabled index not yet evaluated.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - eval_valid is sampled only in WAIT; it is ignored in every other state. Evaluator latency L must be at least 1.
  - On eval_valid: if eval_in_tris and eval_depth < best depth (strict), update best to (hit = 1, index = tri_sel + 1, depth = eval_depth). Ties keep the lower index.
  - Then go to ISSUE if another enabled triangle remains, otherwise DONE.
  - If the counter reaches TIMEOUT without eval_valid: set err_timeout, treat the triangle as a miss, and advance exactly as above.
- DONE:
  - out_valid = 1 with out_color = best index and out_hit = best hit. Both stay stable while out_valid & !out_ready.
  - On out_ready: drop out_valid and return to IDLE.
  - pix_ready rises the cycle after the handshake; back-to-back acceptance is not required.
- Latency from accept cycle A to first out_valid:
  - With E enabled triangles: A + 1 + E*(1 + L) cycles.
  - With E = 0: out_valid at A + 1, colour 0, hit 0.
- Changes on tri_enable after accept have no effect on the pixel in flight.
- err_timeout is cleared only by reset.
- Comparisons are unsigned DEPTH_W. The index + 1 is computed in 3 bits; no overflow, since NUM_TRIS ≤ 7.

Decomposition:
- Package tri_sched_pkg holds:
  - the state encoding (IDLE, ISSUE, WAIT, DONE);
  - TRI_IDX_W = 3;
  - COLOR_BG = 0;
  - DEPTH_FAR = all-ones, as a DEPTH_W-parameterised function or constant.
- One sub-module, tri_next_enabled: combinational priority search over the snapshotted mask, masked to indices ≥ a start index. Outputs the found index and a none-left flag.
- The FSM, best-hit registers and timeout counter stay in tri_scheduler.

Test Plan:
- Mask 4'b0000, pixel (10, 20) -> out_valid exactly 1 cycle after accept; colour 0, hit 0; no eval_strobe.
- Mask 4'b1111, L = 2, evaluator hits tri1 (depth 3) and tri2 (depth 1), misses the others -> 4 strobes with tri_sel 0, 1, 2, 3; out_valid at accept + 13; colour 3.
- Mask 4'b1010, tri1 and tri3 both hit at depth 5 -> strobes only with tri_sel 1 and 3; colour 2 (tie goes to the lower index).
- Evaluator never answers for tri_sel 0, mask 4'b0011, tri1 hits -> WAIT lasts TIMEOUT cycles; err_timeout = 1 and stays set; colour 2.
- Hold out_ready = 0 for 10 cycles after out_valid, and toggle pix_valid and tri_enable meanwhile -> colour and hit stable, pix_ready = 0; accept occurs the cycle after out_ready.
- Assert reset while in WAIT -> outputs 0 immediately (asynchronous); pix_ready = 1 after release; next pixel processed normally; late eval_valid ignored.
